// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, requests instruction memory and fills the IF/ID register.
// Supports stalls, taken-branch redirects and stopping on the HALT opcode.
//
// state  | meaning
// S_FETCH| requesting instructions at pc whenever IF/ID can take one
// S_HALT | HALT word fetched; no requests until a redirect arrives
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  output logic [15:0] instr_out,
  output logic [15:0] pc_plus2_out,
  output logic        instr_valid,
  output logic        halted
);

  localparam logic [15:0] NOP = 16'h0800;

  typedef enum logic {S_FETCH = 1'b0, S_HALT = 1'b1} state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] pc;
  logic [15:0] pc_inc;
  logic        consume;
  logic        accept;
  logic        is_halt;

  assign pc_inc  = pc + 16'd2;
  assign consume = instr_valid & ~stall;
  // A done is only meaningful while the request is up; a redirect suppresses the request.
  assign accept  = imem_req & imem_done;
  assign is_halt = (imem_data[15:11] == 5'b00000);

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (redirect)
      state_next = S_FETCH;
    else if (accept && is_halt)
      state_next = S_HALT;
  end

  always_comb begin
    imem_req = 1'b0;
    halted   = 1'b0;
    if (state == S_FETCH)
      imem_req = ~redirect & (~instr_valid | ~stall);
    else
      halted = 1'b1;
  end

  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      instr_out    <= NOP;
      pc_plus2_out <= 16'h0000;
      instr_valid  <= 1'b0;
    end else if (redirect) begin
      pc          <= redirect_pc;
      instr_out   <= NOP;
      instr_valid <= 1'b0;
    end else if (accept) begin
      instr_out    <= imem_data;
      pc_plus2_out <= pc_inc;
      instr_valid  <= 1'b1;
      // HALT keeps pc on the halt word's address.
      if (!is_halt) pc <= pc_inc;
    end else if (consume) begin
      instr_out   <= NOP;
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; a second instance covers a wrapping reset PC.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, imem_done;
  logic [15:0] redirect_pc, imem_data;
  logic        req_a, valid_a, halted_a;
  logic [15:0] addr_a, instr_a, pcp2_a;
  logic        req_b, valid_b, halted_b;
  logic [15:0] addr_b, instr_b, pcp2_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(16'h0000)) dut_a (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(req_a), .imem_addr(addr_a), .imem_data(imem_data), .imem_done(imem_done),
    .instr_out(instr_a), .pc_plus2_out(pcp2_a), .instr_valid(valid_a), .halted(halted_a)
  );

  fetch_unit #(.RESET_PC(16'hFFFE)) dut_b (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(req_b), .imem_addr(addr_b), .imem_data(imem_data), .imem_done(imem_done),
    .instr_out(instr_b), .pc_plus2_out(pcp2_b), .instr_valid(valid_b), .halted(halted_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    imem_data = 16'h0000; imem_done = 1'b0;
    tick; tick;

    // reset state
    chk("rst_instr", instr_a, 16'h0800);
    chk("rst_pcp2", pcp2_a, 16'h0000);
    chk("rst_valid", {15'd0, valid_a}, 16'd0);
    chk("rst_halted", {15'd0, halted_a}, 16'd0);
    chk("rst_addr", addr_a, 16'h0000);

    // 1: single-cycle memory, one instruction per cycle
    rst = 1'b0; imem_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      imem_data = 16'h2000 + 16'(i);
      #1;
      chk("t1_req", {15'd0, req_a}, 16'd1);
      chk("t1_addr", addr_a, 16'(2 * i));
      tick;
      chk("t1_instr", instr_a, 16'h2000 + 16'(i));
      chk("t1_pcp2", pcp2_a, 16'(2 * i + 2));
      chk("t1_valid", {15'd0, valid_a}, 16'd1);
    end

    // 2: three idle cycles before each done
    for (int k = 0; k < 2; k++) begin
      imem_done = 1'b0;
      for (int w = 0; w < 3; w++) begin
        #1;
        chk("t2_req", {15'd0, req_a}, 16'd1);
        chk("t2_addr_wait", addr_a, 16'(8 + 2 * k));
        tick;
        chk("t2_valid_wait", {15'd0, valid_a}, 16'd0);
      end
      imem_done = 1'b1; imem_data = 16'h2010 + 16'(k);
      tick;
      chk("t2_instr", instr_a, 16'h2010 + 16'(k));
      chk("t2_pcp2", pcp2_a, 16'(10 + 2 * k));
      chk("t2_valid", {15'd0, valid_a}, 16'd1);
    end

    // 3: stall holds IF/ID and pc
    imem_done = 1'b0; stall = 1'b1;
    #1;
    chk("t3_req_stall", {15'd0, req_a}, 16'd0);
    for (int s = 0; s < 3; s++) begin
      tick;
      chk("t3_instr_hold", instr_a, 16'h2011);
      chk("t3_pcp2_hold", pcp2_a, 16'd12);
      chk("t3_valid_hold", {15'd0, valid_a}, 16'd1);
      chk("t3_pc_hold", addr_a, 16'd12);
      chk("t3_req_hold", {15'd0, req_a}, 16'd0);
    end
    stall = 1'b0; imem_done = 1'b1; imem_data = 16'h2012;
    #1;
    chk("t3_req_resume", {15'd0, req_a}, 16'd1);
    chk("t3_addr_resume", addr_a, 16'd12);
    tick;
    chk("t3_instr_resume", instr_a, 16'h2012);
    chk("t3_pcp2_resume", pcp2_a, 16'd14);
    imem_done = 1'b0;
    tick;
    chk("t3_consumed", {15'd0, valid_a}, 16'd0);
    chk("t3_nop", instr_a, 16'h0800);

    // 4: redirect wins over a simultaneous done
    redirect = 1'b1; redirect_pc = 16'h0100; imem_done = 1'b1; imem_data = 16'h2099;
    #1;
    chk("t4_req_redirect", {15'd0, req_a}, 16'd0);
    tick;
    redirect = 1'b0; imem_done = 1'b0;
    #1;
    chk("t4_valid", {15'd0, valid_a}, 16'd0);
    chk("t4_instr", instr_a, 16'h0800);
    chk("t4_addr", addr_a, 16'h0100);
    chk("t4_req", {15'd0, req_a}, 16'd1);

    // 5: HALT at pc 6, then redirect out of it
    redirect = 1'b1; redirect_pc = 16'h0006;
    tick;
    redirect = 1'b0; imem_done = 1'b1; imem_data = 16'h0000;
    tick;
    imem_done = 1'b0;
    #1;
    chk("t5_instr", instr_a, 16'h0000);
    chk("t5_valid", {15'd0, valid_a}, 16'd1);
    chk("t5_pcp2", pcp2_a, 16'd8);
    chk("t5_halted", {15'd0, halted_a}, 16'd1);
    chk("t5_req", {15'd0, req_a}, 16'd0);
    chk("t5_addr", addr_a, 16'd6);
    stall = 1'b1;
    tick;
    chk("t5_valid_stall", {15'd0, valid_a}, 16'd1);
    stall = 1'b0;
    tick;
    chk("t5_valid_consumed", {15'd0, valid_a}, 16'd0);
    chk("t5_halted_still", {15'd0, halted_a}, 16'd1);
    chk("t5_req_still", {15'd0, req_a}, 16'd0);
    tick;
    chk("t5_addr_frozen", addr_a, 16'd6);
    redirect = 1'b1; redirect_pc = 16'h0020;
    tick;
    redirect = 1'b0;
    #1;
    chk("t5_unhalted", {15'd0, halted_a}, 16'd0);
    chk("t5_addr_redirect", addr_a, 16'h0020);
    chk("t5_req_redirect", {15'd0, req_a}, 16'd1);
    imem_done = 1'b1; imem_data = 16'h2030;
    tick;
    chk("t5_instr_after", instr_a, 16'h2030);
    chk("t5_pcp2_after", pcp2_a, 16'h0022);

    // 6: reset mid-stall, and wrapping reset PC on dut_b
    imem_done = 1'b0; stall = 1'b1;
    tick;
    chk("t6_stall_valid", {15'd0, valid_a}, 16'd1);
    rst = 1'b1;
    tick;
    chk("t6_rst_instr", instr_a, 16'h0800);
    chk("t6_rst_valid", {15'd0, valid_a}, 16'd0);
    chk("t6_rst_pcp2", pcp2_a, 16'h0000);
    chk("t6_rst_addr", addr_a, 16'h0000);
    chk("t6_rst_halted", {15'd0, halted_a}, 16'd0);
    rst = 1'b0; stall = 1'b0; imem_done = 1'b1; imem_data = 16'h2040;
    #1;
    chk("t6_b_addr0", addr_b, 16'hFFFE);
    chk("t6_b_req", {15'd0, req_b}, 16'd1);
    tick;
    chk("t6_b_instr", instr_b, 16'h2040);
    chk("t6_b_pcp2", pcp2_b, 16'h0000);
    chk("t6_b_addr1", addr_b, 16'h0000);
    chk("t6_b_valid", {15'd0, valid_b}, 16'd1);
    imem_done = 1'b0;
    tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
